// File: rtl/hongwai_rx.sv
// Decoder for a two-block pulse-distance IR frame: leader, 35 payload bits, connector, 32 payload bits, stop.
// Every timing window is fixed at elaboration from the clock rate and the tolerance.
`timescale 1ns/1ps
module hongwai_rx #(
   parameter int CYC_US  = 125,
   parameter int TOL_PCT = 25,
   parameter int US_DIV  = 1   // divides every nominal duration; 1 for real hardware
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ir_in,
   output logic [34:0] data35,
   output logic [31:0] data32,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic        busy
);

   function automatic logic [31:0] win_lo(input int unsigned us);
      longint unsigned num, den;
      num = longint'(us) * longint'(CYC_US) * longint'(100 - TOL_PCT);
      den = 64'd100 * longint'(US_DIV);
      return 32'((num + den - 64'd1) / den);
   endfunction

   function automatic logic [31:0] win_hi(input int unsigned us);
      longint unsigned num, den;
      num = longint'(us) * longint'(CYC_US) * longint'(100 + TOL_PCT);
      den = 64'd100 * longint'(US_DIV);
      return 32'(num / den);
   endfunction

   function automatic logic [31:0] nom_cyc(input int unsigned us);
      return 32'((longint'(us) * longint'(CYC_US)) / longint'(US_DIV));
   endfunction

   localparam logic [31:0] LM_LO  = win_lo(9000);
   localparam logic [31:0] LM_HI  = win_hi(9000);
   localparam logic [31:0] LS_LO  = win_lo(4500);
   localparam logic [31:0] LS_HI  = win_hi(4500);
   localparam logic [31:0] BM_LO  = win_lo(750);
   localparam logic [31:0] BM_HI  = win_hi(750);
   localparam logic [31:0] ZS_LO  = win_lo(450);
   localparam logic [31:0] ZS_HI  = win_hi(450);
   localparam logic [31:0] OS_LO  = win_lo(1500);
   localparam logic [31:0] OS_HI  = win_hi(1500);
   localparam logic [31:0] CS_LO  = win_lo(20000);
   localparam logic [31:0] CS_HI  = win_hi(20000);
   localparam logic [31:0] TO_CYC = nom_cyc(25000);

   typedef enum logic [3:0] {
      IDLE, LEAD_M, LEAD_S, B35_M, B35_S, CON_M, CON_S, B32_M, B32_S, STOP_M
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, ir_s_q;
   logic [21:0] cnt_q, cnt_d;
   logic [5:0]  bits_q, bits_d;
   logic [34:0] sh35_q, sh35_d, data35_q, data35_d;
   logic [31:0] sh32_q, sh32_d, data32_q, data32_d;
   logic        fv_q, fv_d, fe_q, fe_d;
   logic [1:0]  ec_q, ec_d;

   logic        edge_w;
   logic [31:0] width_w;
   logic        in_lm, in_ls, in_bm, in_zs, in_os, in_cs;

   // Edge is seen one cycle early from the first flop so the width and the new level line up.
   assign edge_w  = sync1_q ^ ir_s_q;
   assign width_w = {10'd0, cnt_q} + 32'd1;
   assign cnt_d   = edge_w ? 22'd0 : ((&cnt_q) ? cnt_q : cnt_q + 22'd1);

   assign in_lm = (width_w >= LM_LO) && (width_w <= LM_HI);
   assign in_ls = (width_w >= LS_LO) && (width_w <= LS_HI);
   assign in_bm = (width_w >= BM_LO) && (width_w <= BM_HI);
   assign in_zs = (width_w >= ZS_LO) && (width_w <= ZS_HI);
   assign in_os = (width_w >= OS_LO) && (width_w <= OS_HI);
   assign in_cs = (width_w >= CS_LO) && (width_w <= CS_HI);

   always_comb begin
      logic       abort;
      logic [1:0] code;
      state_d  = state_q;
      bits_d   = bits_q;
      sh35_d   = sh35_q;
      sh32_d   = sh32_q;
      data35_d = data35_q;
      data32_d = data32_q;
      fv_d     = 1'b0;
      fe_d     = 1'b0;
      ec_d     = ec_q;
      abort    = 1'b0;
      code     = 2'd0;

      case (state_q)
         IDLE:   if (edge_w && ir_s_q) state_d = LEAD_M;
         LEAD_M: if (edge_w) begin
                    if (in_lm) state_d = LEAD_S;
                    else begin abort = 1'b1; code = 2'd1; end
                 end
         LEAD_S: if (edge_w) begin
                    if (in_ls) begin state_d = B35_M; bits_d = 6'd0; end
                    else begin abort = 1'b1; code = 2'd2; end
                 end
         B35_M, CON_M, B32_M: if (edge_w) begin
                    if (!in_bm) begin abort = 1'b1; code = 2'd1; end
                    else if (state_q == B35_M) state_d = B35_S;
                    else if (state_q == CON_M) state_d = CON_S;
                    else state_d = B32_S;
                 end
         B35_S:  if (edge_w) begin
                    if (in_zs || in_os) begin
                       sh35_d  = {sh35_q[33:0], in_os};
                       bits_d  = bits_q + 6'd1;
                       state_d = (bits_q == 6'd34) ? CON_M : B35_M;
                    end else begin abort = 1'b1; code = 2'd2; end
                 end
         CON_S:  if (edge_w) begin
                    if (in_cs) begin state_d = B32_M; bits_d = 6'd0; end
                    else begin abort = 1'b1; code = 2'd2; end
                 end
         B32_S:  if (edge_w) begin
                    if (in_zs || in_os) begin
                       sh32_d = {sh32_q[30:0], in_os};
                       bits_d = bits_q + 6'd1;
                       if (bits_q == 6'd31) begin
                          state_d  = STOP_M;
                          data35_d = sh35_q;
                          data32_d = {sh32_q[30:0], in_os};
                          fv_d     = 1'b1;
                       end else begin
                          state_d = B32_M;
                       end
                    end else begin abort = 1'b1; code = 2'd2; end
                 end
         STOP_M: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A level that has lasted the full timeout with no edge ends the frame.
      if (state_q != IDLE && state_q != STOP_M && !edge_w && width_w >= TO_CYC) begin
         abort = 1'b1;
         code  = 2'd3;
      end

      if (abort) begin
         state_d  = IDLE;
         fe_d     = 1'b1;
         fv_d     = 1'b0;
         ec_d     = code;
         data35_d = data35_q;
         data32_d = data32_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         ir_s_q   <= 1'b1;
         cnt_q    <= 22'd0;
         state_q  <= IDLE;
         bits_q   <= 6'd0;
         data35_q <= 35'd0;
         data32_q <= 32'd0;
         fv_q     <= 1'b0;
         fe_q     <= 1'b0;
         ec_q     <= 2'd0;
      end else begin
         sync1_q  <= ir_in;
         ir_s_q   <= sync1_q;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         bits_q   <= bits_d;
         data35_q <= data35_d;
         data32_q <= data32_d;
         fv_q     <= fv_d;
         fe_q     <= fe_d;
         ec_q     <= ec_d;
      end
   end

   always_ff @(posedge clk) begin
      sh35_q <= sh35_d;
      sh32_q <= sh32_d;
   end

   assign data35      = data35_q;
   assign data32      = data32_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign err_code    = ec_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_hongwai_rx.sv
// Self-checking bench for hongwai_rx: frames are built as mark/space duration lists and decoded by a reference model.
`timescale 1ns/1ps
module tb_hongwai_rx;
   localparam int CYC = 1;
   localparam int DIV = 50;
   localparam int TOL = 25;

   localparam int N_LM = 9000 * CYC / DIV;
   localparam int N_LS = 4500 * CYC / DIV;
   localparam int N_BM = 750 * CYC / DIV;
   localparam int N_ZS = 450 * CYC / DIV;
   localparam int N_OS = 1500 * CYC / DIV;
   localparam int N_CS = 20000 * CYC / DIV;
   localparam int N_TO = 25000 * CYC / DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ir_in = 1'b1;
   logic [34:0] data35;
   logic [31:0] data32;
   logic        frame_valid, frame_err, busy;
   logic [1:0]  err_code;

   hongwai_rx #(.CYC_US(CYC), .TOL_PCT(TOL), .US_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .ir_in(ir_in), .data35(data35), .data32(data32),
      .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0, fe_cnt = 0, both_cnt = 0;
   logic [34:0] cap35 = '0;
   logic [31:0] cap32 = '0;
   logic [34:0] prev35 = '0;
   logic [31:0] prev32 = '0;

   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cnt <= fv_cnt + 1;
         cap35  <= data35;
         cap32  <= data32;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (frame_valid && frame_err) both_cnt <= both_cnt + 1;
   end

   // segment categories: 0 lead mark, 1 lead space, 2 bit mark (35), 3 bit space (35),
   // 4 connect mark, 5 connect space, 6 bit mark (32), 7 bit space (32), 8 stop mark
   logic seg_lv[$];
   int   seg_d[$];
   int   seg_cat[$];

   function automatic int dur(input int nom, input int pct);
      return (nom * pct + 50) / 100;
   endfunction

   function automatic bit in_win(input int d, input int nom);
      return (d * 100 >= nom * (100 - TOL)) && (d * 100 <= nom * (100 + TOL));
   endfunction

   task automatic push(input logic lv, input int cat, input int nom, input int pct, input bit jit);
      int p;
      p = jit ? (78 + int'($urandom_range(0, 44))) : pct;
      seg_lv.push_back(lv);
      seg_cat.push_back(cat);
      seg_d.push_back(dur(nom, p));
   endtask

   task automatic build(input logic [34:0] a, input logic [31:0] b, input int pct, input bit jit);
      seg_lv.delete(); seg_d.delete(); seg_cat.delete();
      push(1'b0, 0, N_LM, pct, jit);
      push(1'b1, 1, N_LS, pct, jit);
      for (int i = 34; i >= 0; i--) begin
         push(1'b0, 2, N_BM, pct, jit);
         push(1'b1, 3, a[i] ? N_OS : N_ZS, pct, jit);
      end
      push(1'b0, 4, N_BM, pct, jit);
      push(1'b1, 5, N_CS, pct, jit);
      for (int i = 31; i >= 0; i--) begin
         push(1'b0, 6, N_BM, pct, jit);
         push(1'b1, 7, b[i] ? N_OS : N_ZS, pct, jit);
      end
      push(1'b0, 8, N_BM, pct, jit);
   endtask

   // Reference decoder: walks the duration list against the nominal windows.
   task automatic model(output bit v, output int code, output int eidx,
                        output logic [34:0] m35, output logic [31:0] m32);
      v = 0; code = 0; eidx = 0; m35 = '0; m32 = '0;
      for (int i = 0; i < seg_d.size(); i++) begin
         int d;
         d = seg_d[i];
         if (seg_cat[i] != 8 && d > N_TO) begin code = 3; eidx = i; return; end
         case (seg_cat[i])
            0: if (!in_win(d, N_LM)) code = 1;
            1: if (!in_win(d, N_LS)) code = 2;
            2, 4, 6: if (!in_win(d, N_BM)) code = 1;
            5: if (!in_win(d, N_CS)) code = 2;
            3, 7: begin
               if (in_win(d, N_ZS) || in_win(d, N_OS)) begin
                  if (seg_cat[i] == 3) m35 = {m35[33:0], in_win(d, N_OS)};
                  else                 m32 = {m32[30:0], in_win(d, N_OS)};
               end else code = 2;
            end
            default: begin v = 1; return; end
         endcase
         if (code != 0) begin eidx = i; return; end
      end
   endtask

   task automatic drive_level(input logic lv, input int d);
      ir_in = lv;
      repeat (d) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string name);
      bit v; int code, eidx, last, fv0, fe0;
      logic [34:0] m35; logic [31:0] m32;
      model(v, code, eidx, m35, m32);
      fv0 = fv_cnt; fe0 = fe_cnt;
      last = (code != 0 && eidx + 1 < seg_d.size()) ? eidx + 1 : seg_d.size() - 1;
      drive_level(1'b1, 10);
      for (int i = 0; i <= last; i++) drive_level(seg_lv[i], seg_d[i]);
      drive_level(1'b1, 40);
      @(negedge clk);
      checks++; if (fv_cnt - fv0 !== (v ? 1 : 0)) begin errors++; $display("FAIL %s valid_pulses got %0d want %0d", name, fv_cnt - fv0, v ? 1 : 0); end
      checks++; if (fe_cnt - fe0 !== (code != 0 ? 1 : 0)) begin errors++; $display("FAIL %s err_pulses got %0d want %0d", name, fe_cnt - fe0, code != 0 ? 1 : 0); end
      if (v) begin
         checks++; if (cap35 !== m35) begin errors++; $display("FAIL %s data35 got %h want %h", name, cap35, m35); end
         checks++; if (cap32 !== m32) begin errors++; $display("FAIL %s data32 got %h want %h", name, cap32, m32); end
         prev35 = m35; prev32 = m32;
      end else begin
         checks++; if (err_code !== 2'(code)) begin errors++; $display("FAIL %s err_code got %0d want %0d", name, err_code, code); end
         checks++; if (data35 !== prev35 || data32 !== prev32) begin errors++; $display("FAIL %s data_kept got %h/%h want %h/%h", name, data35, data32, prev35, prev32); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
   endtask

   task automatic test_reset();
      rst = 1'b1; ir_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (data35 !== 35'd0) begin errors++; $display("FAIL reset data35 got %h want 0", data35); end
      checks++; if (data32 !== 32'd0) begin errors++; $display("FAIL reset data32 got %h want 0", data32); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset frame_valid got %b want 0", frame_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err got %b want 0", frame_err); end
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset err_code got %0d want 0", err_code); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      build(35'b10000010000100000000010000001010010, 32'h08040006, 100, 0);
      run_frame("nominal");
   endtask

   task automatic test_tolerance();
      build(35'h5_5AA5_3C3C, 32'hDEADBEEF, 120, 0); run_frame("plus20");
      build(35'h2_1234_5678, 32'h0F0F00FF, 80, 0);  run_frame("minus20");
      build(35'h7_FFFF_0000, 32'h12345678, 130, 0); run_frame("plus30");
      build(35'h0_0000_FFFF, 32'h87654321, 70, 0);  run_frame("minus30");
      build(35'h3_3333_3333, 32'hCAFEF00D, 100, 0);
      seg_d[13] = 15;
      run_frame("space_gap");
   endtask

   task automatic test_timeout();
      int n;
      int fv0;
      fv0 = fv_cnt;
      build(35'h4_0000_0001, 32'h1, 100, 0);
      drive_level(1'b1, 10);
      for (int i = 0; i <= 8; i++) drive_level(seg_lv[i], seg_d[i]);
      ir_in = 1'b1;
      n = 0;
      while (n < 2000) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (frame_err) break;
      end
      checks++; if (n !== N_TO + 2) begin errors++; $display("FAIL timeout latency got %0d want %0d", n, N_TO + 2); end
      checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL timeout err_code got %0d want 3", err_code); end
      checks++; if (data35 !== prev35 || data32 !== prev32) begin errors++; $display("FAIL timeout data_kept got %h/%h want %h/%h", data35, data32, prev35, prev32); end
      checks++; if (fv_cnt !== fv0) begin errors++; $display("FAIL timeout valid_pulses got %0d want %0d", fv_cnt, fv0); end
      drive_level(1'b1, 20);
   endtask

   task automatic test_short_leader();
      build(35'h1_2345_6789, 32'hA5A5A5A5, 100, 0);
      seg_d[0] = 3000 * CYC / DIV;
      run_frame("short_leader");
      build(35'h6_DB6D_B6DB, 32'h5A5A5A5A, 100, 0);
      run_frame("after_short");
   endtask

   task automatic test_reset_midframe();
      int fe0;
      build(35'h7_0F0F_0F0F, 32'hF0F0F0F0, 100, 0);
      fe0 = fe_cnt;
      drive_level(1'b1, 10);
      for (int i = 0; i <= 73; i++) drive_level(seg_lv[i], seg_d[i]);
      drive_level(1'b0, 5);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset busy_before got %b want 1", busy); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; ir_in = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++; if (data35 !== 35'd0 || data32 !== 32'd0) begin errors++; $display("FAIL midreset data got %h/%h want 0/0", data35, data32); end
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL midreset err_code got %0d want 0", err_code); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy got %b want 0", busy); end
      checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL midreset err_pulses got %0d want %0d", fe_cnt, fe0); end
      prev35 = '0; prev32 = '0;
      @(posedge clk); #1;
      build(35'h5_4321_8765, 32'h0BADCAFE, 100, 0);
      run_frame("after_midreset");
   endtask

   task automatic test_glitch();
      int fv0, fe0;
      fv0 = fv_cnt; fe0 = fe_cnt;
      drive_level(1'b1, 10);
      drive_level(1'b0, 100);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch busy got %b want 1", busy); end
      drive_level(1'b1, 40);
      @(negedge clk);
      checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL glitch err_pulses got %0d want 1", fe_cnt - fe0); end
      checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL glitch err_code got %0d want 1", err_code); end
      checks++; if (fv_cnt !== fv0) begin errors++; $display("FAIL glitch valid_pulses got %0d want %0d", fv_cnt, fv0); end
      checks++; if (data35 !== prev35 || data32 !== prev32) begin errors++; $display("FAIL glitch data_kept got %h/%h want %h/%h", data35, data32, prev35, prev32); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         build({3'($urandom), 32'($urandom)}, 32'($urandom), 100, 1);
         run_frame("random_jitter");
      end
      build({3'($urandom), 32'($urandom)}, 32'($urandom), 100, 1);
      begin
         int k;
         k = 2 + int'($urandom_range(0, 69));
         seg_d[k] = seg_d[k] * 14 / 10;
      end
      run_frame("random_stretch");
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_pulses got %0d want 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_tolerance();
      test_timeout();
      test_short_leader();
      test_glitch();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
